// File: rtl/i2s_receiver.sv
// i2s_receiver: serial-to-parallel I2S receiver in the s_clk domain.
//
// Locks to word_select edges and deserialises 16-bit MSB-first samples with the
// standard one-bit delay after each word_select transition. Completed samples are
// presented on a valid/ready interface.
//
// Optional feature macro: I2S_RX_RIGHT_CHANNEL_EN
//   defined   - right slot captured too; left+right delivered together after the
//               right slot; short-slot check on both slots.
//   undefined - left-only; sound_out_right tied to 0; one sample per frame.
//
// Ports:
//   s_clk            in   bit clock, all logic on posedge
//   reset            in   synchronous active-low reset
//   word_select      in   channel select, 0 = left slot, 1 = right slot
//   sound_bit_in     in   serial data, MSB first
//   sample_ready     in   consumer accepts the held sample
//   sound_out_left   out  last completed left sample
//   sound_out_right  out  last completed right sample (0 in left-only build)
//   sample_valid     out  a sample is held and not yet accepted
//   overrun          out  1-cycle pulse: new sample overwrote an unaccepted one
//   frame_error      out  1-cycle pulse: short or overlong slot
//   bit_count        out  position of the bit just sampled in the slot, 0 = delay bit

module i2s_receiver #(
    parameter int unsigned MAX_SLOT_BITS = 32
) (
    input  logic        s_clk,
    input  logic        reset,
    input  logic        word_select,
    input  logic        sound_bit_in,
    input  logic        sample_ready,
    output logic [15:0] sound_out_left,
    output logic [15:0] sound_out_right,
    output logic        sample_valid,
    output logic        overrun,
    output logic        frame_error,
    output logic [5:0]  bit_count
);

    // Last legal bit position in one slot; one more non-edge sample is an overlong slot.
    localparam logic [5:0] LastBit = 6'(MAX_SLOT_BITS - 1);

    typedef enum logic [1:0] {
        StSync,
        StLeft,
        StRight
    } state_e;

    state_e      state_q;
    logic        ws_prev_q;
    logic [15:0] shift_left_q;

    logic        ws_rise;
    logic        ws_fall;
    logic        capture;
    logic        last_data;
    logic        slot_full;
    logic        accept;
    logic [15:0] left_word;

`ifdef I2S_RX_RIGHT_CHANNEL_EN
    logic [15:0] shift_right_q;
    logic [15:0] left_buf_q;
    logic        left_ok_q;
    logic [15:0] right_out_q;
    logic [15:0] right_word;

    assign right_word      = {shift_right_q[14:0], sound_bit_in};
    assign sound_out_right = right_out_q;
`else
    assign sound_out_right = '0;
`endif

    assign ws_rise   = word_select & ~ws_prev_q;
    assign ws_fall   = ~word_select & ws_prev_q;
    // bit_count holds the position already sampled, so this edge samples bit_count+1.
    assign capture   = (bit_count < 6'd16);
    assign last_data = (bit_count == 6'd15);
    // All 16 data bits have been sampled once bit_count reaches 16.
    assign slot_full = (bit_count >= 6'd16);
    assign accept    = sample_valid & sample_ready;
    assign left_word = {shift_left_q[14:0], sound_bit_in};

    always_ff @(posedge s_clk) begin
        if (!reset) begin
            state_q        <= StSync;
            ws_prev_q      <= 1'b0;
            bit_count      <= '0;
            shift_left_q   <= '0;
            sound_out_left <= '0;
            sample_valid   <= 1'b0;
            overrun        <= 1'b0;
            frame_error    <= 1'b0;
`ifdef I2S_RX_RIGHT_CHANNEL_EN
            shift_right_q  <= '0;
            left_buf_q     <= '0;
            left_ok_q      <= 1'b0;
            right_out_q    <= '0;
`endif
        end else begin
            ws_prev_q   <= word_select;
            overrun     <= 1'b0;
            frame_error <= 1'b0;
            // A completion later in this block overrides the clear, keeping valid high.
            if (accept) begin
                sample_valid <= 1'b0;
            end

            case (state_q)
                StSync: begin
                    if (ws_fall) begin
                        state_q   <= StLeft;
                        bit_count <= '0;
                    end
                end

                StLeft: begin
                    if (ws_rise) begin
                        if (!slot_full) begin
                            frame_error <= 1'b1;
`ifdef I2S_RX_RIGHT_CHANNEL_EN
                            left_ok_q   <= 1'b0;
`endif
                        end
                        state_q      <= StRight;
                        bit_count    <= '0;
                        shift_left_q <= '0;
                    end else if (bit_count == LastBit) begin
                        frame_error <= 1'b1;
                        state_q     <= StSync;
                        bit_count   <= '0;
`ifdef I2S_RX_RIGHT_CHANNEL_EN
                        left_ok_q   <= 1'b0;
`endif
                    end else begin
                        bit_count <= bit_count + 6'd1;
                        if (capture) begin
                            shift_left_q <= left_word;
                        end
                        if (last_data) begin
`ifdef I2S_RX_RIGHT_CHANNEL_EN
                            // Hold the left word until its right partner completes.
                            left_buf_q <= left_word;
                            left_ok_q  <= 1'b1;
`else
                            sound_out_left <= left_word;
                            sample_valid   <= 1'b1;
                            overrun        <= sample_valid & ~sample_ready;
`endif
                        end
                    end
                end

                StRight: begin
                    if (ws_fall) begin
`ifdef I2S_RX_RIGHT_CHANNEL_EN
                        if (!slot_full) begin
                            frame_error <= 1'b1;
                            left_ok_q   <= 1'b0;
                        end
                        shift_right_q <= '0;
`endif
                        state_q   <= StLeft;
                        bit_count <= '0;
                    end else if (bit_count == LastBit) begin
                        frame_error <= 1'b1;
                        state_q     <= StSync;
                        bit_count   <= '0;
`ifdef I2S_RX_RIGHT_CHANNEL_EN
                        left_ok_q   <= 1'b0;
`endif
                    end else begin
                        bit_count <= bit_count + 6'd1;
`ifdef I2S_RX_RIGHT_CHANNEL_EN
                        if (capture) begin
                            shift_right_q <= right_word;
                        end
                        // A stereo sample is only delivered if its left half survived.
                        if (last_data && left_ok_q) begin
                            sound_out_left <= left_buf_q;
                            right_out_q    <= right_word;
                            sample_valid   <= 1'b1;
                            overrun        <= sample_valid & ~sample_ready;
                            left_ok_q      <= 1'b0;
                        end
`endif
                    end
                end

                default: begin
                    state_q   <= StSync;
                    bit_count <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2s_receiver.sv
// Self-checking bench for i2s_receiver: an I2S transmitter model drives framed
// words, and expectations come from a frame-level model of the receiver rules.

module tb_i2s_receiver;

`ifdef I2S_RX_RIGHT_CHANNEL_EN
    localparam bit Stereo = 1'b1;
`else
    localparam bit Stereo = 1'b0;
`endif

    logic        s_clk;
    logic        reset;
    logic        word_select;
    logic        sound_bit_in;
    logic        sample_ready;
    logic [15:0] sound_out_left;
    logic [15:0] sound_out_right;
    logic        sample_valid;
    logic        overrun;
    logic        frame_error;
    logic [5:0]  bit_count;

    int checks    = 0;
    int passed    = 0;
    int cyc       = 0;
    int pulses    = 0;
    int ovr_cnt   = 0;
    int fe_cnt    = 0;
    int last_rise = 0;
    int last_fe   = 0;
    logic valid_prev = 1'b0;
    logic rdy_base   = 1'b1;

    // Model of the delivered sample.
    logic [15:0] exp_left  = 16'h0;
    logic [15:0] exp_right = 16'h0;

    i2s_receiver #(.MAX_SLOT_BITS(32)) dut (
        .s_clk          (s_clk),
        .reset          (reset),
        .word_select    (word_select),
        .sound_bit_in   (sound_bit_in),
        .sample_ready   (sample_ready),
        .sound_out_left (sound_out_left),
        .sound_out_right(sound_out_right),
        .sample_valid   (sample_valid),
        .overrun        (overrun),
        .frame_error    (frame_error),
        .bit_count      (bit_count)
    );

    initial s_clk = 1'b0;
    always #5 s_clk = ~s_clk;

    function automatic logic [15:0] right_model(input logic [15:0] r);
        return Stereo ? r : 16'h0;
    endfunction

    // One bit period: drive, wait for the sampling edge, observe 1 time unit later.
    task automatic tick(input logic ws, input logic b);
        word_select  = ws;
        sound_bit_in = b;
        @(posedge s_clk);
        #1;
        cyc++;
        if (sample_valid && !valid_prev) begin
            pulses++;
            last_rise = cyc;
        end
        valid_prev = sample_valid;
        if (overrun) ovr_cnt++;
        if (frame_error) begin
            fe_cnt++;
            last_fe = cyc;
        end
    endtask

    // Transmitter slot: random delay bit, then MSB..LSB, then random filler.
    task automatic send_slot(input logic ws, input logic [15:0] word, input int len,
                             input logic done_rdy);
        for (int i = 0; i < len; i++) begin
            logic b;
            if (i >= 1 && i <= 16) b = word[16-i];
            else b = 1'($urandom_range(0, 1));
            sample_ready = (i == 16) ? done_rdy : rdy_base;
            tick(ws, b);
        end
        sample_ready = rdy_base;
    endtask

    // Full 34-cycle frame; done_rdy is the ready level on the completing bit.
    task automatic send_frame(input logic [15:0] l, input logic [15:0] r,
                              input logic done_rdy);
        if (Stereo) begin
            send_slot(1'b0, l, 17, rdy_base);
            send_slot(1'b1, r, 17, done_rdy);
        end else begin
            send_slot(1'b0, l, 17, done_rdy);
            send_slot(1'b1, r, 17, rdy_base);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1);
        checks++; if (sound_out_left !== 16'h0) $display("FAIL rst_left got %h want 0000", sound_out_left); else passed++;
        checks++; if (sound_out_right !== 16'h0) $display("FAIL rst_right got %h want 0000", sound_out_right); else passed++;
        checks++; if (sample_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", sample_valid); else passed++;
        checks++; if (overrun !== 1'b0) $display("FAIL rst_overrun got %b want 0", overrun); else passed++;
        checks++; if (frame_error !== 1'b0) $display("FAIL rst_ferr got %b want 0", frame_error); else passed++;
        checks++; if (bit_count !== 6'd0) $display("FAIL rst_bitcnt got %0d want 0", bit_count); else passed++;
        reset = 1'b1;
    endtask

    task automatic test_loopback();
        int p0;
        int r0;
        logic [15:0] r;
        p0 = pulses;
        r = 16'($urandom);
        send_frame(16'hA5C3, r, rdy_base);
        checks++; if (pulses !== p0) $display("FAIL loop_first_skipped got %0d want %0d", pulses, p0); else passed++;
        send_frame(16'hA5C3, r, rdy_base);
        exp_left  = 16'hA5C3;
        exp_right = right_model(r);
        r0 = last_rise;
        checks++; if (sound_out_left !== exp_left) $display("FAIL loop_left got %h want %h", sound_out_left, exp_left); else passed++;
        checks++; if (sound_out_right !== exp_right) $display("FAIL loop_right got %h want %h", sound_out_right, exp_right); else passed++;
        checks++; if (pulses !== p0 + 1) $display("FAIL loop_pulse got %0d want %0d", pulses, p0 + 1); else passed++;
        for (int f = 0; f < 3; f++) send_frame(16'hA5C3, r, rdy_base);
        checks++; if (last_rise - r0 !== 102) $display("FAIL loop_period got %0d want 102", last_rise - r0); else passed++;
        checks++; if (pulses !== p0 + 4) $display("FAIL loop_pulses got %0d want %0d", pulses, p0 + 4); else passed++;
        checks++; if (fe_cnt !== 0) $display("FAIL loop_ferr got %0d want 0", fe_cnt); else passed++;
    endtask

    task automatic test_sequence();
        logic [15:0] words [5];
        int p0;
        words[0] = 16'h8001;
        words[1] = 16'h7FFE;
        words[2] = 16'h0000;
        words[3] = 16'($urandom);
        words[4] = 16'($urandom);
        p0 = pulses;
        for (int k = 0; k < 5; k++) begin
            logic [15:0] r;
            r = 16'($urandom);
            send_frame(words[k], r, rdy_base);
            exp_left  = words[k];
            exp_right = right_model(r);
            checks++; if (sound_out_left !== exp_left) $display("FAIL seq_left[%0d] got %h want %h", k, sound_out_left, exp_left); else passed++;
            checks++; if (sound_out_right !== exp_right) $display("FAIL seq_right[%0d] got %h want %h", k, sound_out_right, exp_right); else passed++;
        end
        checks++; if (pulses !== p0 + 5) $display("FAIL seq_pulses got %0d want %0d", pulses, p0 + 5); else passed++;
        checks++; if (bit_count !== 6'd16) $display("FAIL seq_slot_end_bitcnt got %0d want 16", bit_count); else passed++;
    endtask

    task automatic test_overrun();
        int o0;
        o0 = ovr_cnt;
        rdy_base = 1'b0;
        send_frame(16'h1111, 16'h5555, 1'b0);
        send_frame(16'h2222, 16'h6666, 1'b0);
        exp_left  = 16'h2222;
        exp_right = right_model(16'h6666);
        checks++; if (ovr_cnt - o0 !== 1) $display("FAIL ovr_count got %0d want 1", ovr_cnt - o0); else passed++;
        checks++; if (sound_out_left !== exp_left) $display("FAIL ovr_left got %h want %h", sound_out_left, exp_left); else passed++;
        checks++; if (sound_out_right !== exp_right) $display("FAIL ovr_right got %h want %h", sound_out_right, exp_right); else passed++;
        checks++; if (sample_valid !== 1'b1) $display("FAIL ovr_valid_held got %b want 1", sample_valid); else passed++;
        // Accept and completion on the same edge: new word loads, no overrun.
        send_frame(16'h3333, 16'h7777, 1'b1);
        exp_left = 16'h3333;
        checks++; if (sound_out_left !== exp_left) $display("FAIL same_edge_left got %h want %h", sound_out_left, exp_left); else passed++;
        checks++; if (sample_valid !== 1'b1) $display("FAIL same_edge_valid got %b want 1", sample_valid); else passed++;
        checks++; if (ovr_cnt - o0 !== 1) $display("FAIL same_edge_ovr got %0d want 1", ovr_cnt - o0); else passed++;
        rdy_base = 1'b1;
        sample_ready = 1'b1;
        tick(1'b1, 1'b0);
        checks++; if (sample_valid !== 1'b0) $display("FAIL ovr_accept got %b want 0", sample_valid); else passed++;
        exp_right = right_model(16'h7777);
    endtask

    task automatic test_short_slot();
        int f0;
        int p0;
        logic [15:0] r;
        f0 = fe_cnt;
        p0 = pulses;
        send_slot(1'b0, 16'($urandom), 10, rdy_base);
        send_slot(1'b1, 16'($urandom), 17, rdy_base);
        checks++; if (fe_cnt - f0 !== 1) $display("FAIL short_ferr got %0d want 1", fe_cnt - f0); else passed++;
        checks++; if (pulses !== p0) $display("FAIL short_no_valid got %0d want %0d", pulses, p0); else passed++;
        r = 16'($urandom);
        send_frame(16'h0F0F, r, rdy_base);
        exp_left  = 16'h0F0F;
        exp_right = right_model(r);
        checks++; if (sound_out_left !== exp_left) $display("FAIL short_recover_left got %h want %h", sound_out_left, exp_left); else passed++;
        checks++; if (sound_out_right !== exp_right) $display("FAIL short_recover_right got %h want %h", sound_out_right, exp_right); else passed++;
        checks++; if (fe_cnt - f0 !== 1) $display("FAIL short_recover_ferr got %0d want 1", fe_cnt - f0); else passed++;
    endtask

    task automatic test_overlong();
        int f0;
        int p0;
        int start;
        logic [15:0] w;
        logic [15:0] w2;
        logic [15:0] r2;
        f0 = fe_cnt;
        p0 = pulses;
        start = cyc;
        w = 16'($urandom);
        send_slot(1'b0, w, 40, rdy_base);
        // Left-only build still completes the sample at bit 16 before the overflow.
        if (!Stereo) exp_left = w;
        checks++; if (fe_cnt - f0 !== 1) $display("FAIL long_ferr got %0d want 1", fe_cnt - f0); else passed++;
        checks++; if (last_fe - start !== 33) $display("FAIL long_ferr_time got %0d want 33", last_fe - start); else passed++;
        checks++; if (bit_count !== 6'd0) $display("FAIL long_sync_bitcnt got %0d want 0", bit_count); else passed++;
        checks++; if (pulses - p0 !== (Stereo ? 0 : 1)) $display("FAIL long_pulses got %0d want %0d", pulses - p0, Stereo ? 0 : 1); else passed++;
        checks++; if (sound_out_left !== exp_left) $display("FAIL long_left got %h want %h", sound_out_left, exp_left); else passed++;
        send_slot(1'b1, 16'($urandom), 17, rdy_base);
        w2 = 16'($urandom);
        r2 = 16'($urandom);
        p0 = pulses;
        send_frame(w2, r2, rdy_base);
        exp_left  = w2;
        exp_right = right_model(r2);
        checks++; if (sound_out_left !== exp_left) $display("FAIL long_recover_left got %h want %h", sound_out_left, exp_left); else passed++;
        checks++; if (sound_out_right !== exp_right) $display("FAIL long_recover_right got %h want %h", sound_out_right, exp_right); else passed++;
        checks++; if (pulses - p0 !== 1) $display("FAIL long_recover_pulse got %0d want 1", pulses - p0); else passed++;
    endtask

    task automatic test_reset_midframe();
        int p0;
        logic [15:0] w3;
        send_slot(1'b0, 16'($urandom), 9, rdy_base);
        checks++; if (bit_count !== 6'd8) $display("FAIL mid_pre_bitcnt got %0d want 8", bit_count); else passed++;
        reset = 1'b0;
        tick(1'b0, 1'b1);
        reset = 1'b1;
        checks++; if (sound_out_left !== 16'h0) $display("FAIL mid_rst_left got %h want 0000", sound_out_left); else passed++;
        checks++; if (sound_out_right !== 16'h0) $display("FAIL mid_rst_right got %h want 0000", sound_out_right); else passed++;
        checks++; if (sample_valid !== 1'b0) $display("FAIL mid_rst_valid got %b want 0", sample_valid); else passed++;
        checks++; if (bit_count !== 6'd0) $display("FAIL mid_rst_bitcnt got %0d want 0", bit_count); else passed++;
        p0 = pulses;
        // No falling edge yet: the rest of this frame must be ignored.
        send_slot(1'b0, 16'($urandom), 10, rdy_base);
        send_slot(1'b1, 16'($urandom), 17, rdy_base);
        checks++; if (pulses !== p0) $display("FAIL mid_no_sample got %0d want %0d", pulses, p0); else passed++;
        w3 = 16'($urandom);
        send_frame(w3, 16'hBEEF, rdy_base);
        exp_left  = w3;
        exp_right = right_model(16'hBEEF);
        checks++; if (pulses - p0 !== 1) $display("FAIL mid_one_pulse got %0d want 1", pulses - p0); else passed++;
        checks++; if (sound_out_left !== exp_left) $display("FAIL mid_left got %h want %h", sound_out_left, exp_left); else passed++;
        checks++; if (sound_out_right !== exp_right) $display("FAIL mid_right got %h want %h", sound_out_right, exp_right); else passed++;
    endtask

    initial begin
        reset        = 1'b0;
        word_select  = 1'b0;
        sound_bit_in = 1'b0;
        sample_ready = 1'b1;
        test_reset();
        test_loopback();
        test_sequence();
        test_overrun();
        test_short_slot();
        test_overlong();
        test_reset_midframe();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
